// File: rtl/edge_arb_pkg.sv
// Shared types and constants for the edge event arbiter: FSM encoding,
// edge-kind values and the arm-counter width helper.
package edge_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } fsm_state_t;

   localparam logic EVT_FALL = 1'b0;
   localparam logic EVT_RISE = 1'b1;

   // The arm counter must hold values 0..stages+1.
   function automatic int arm_width(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event output stream of the edge event arbiter (channel id plus edge kind).
// Handshake: an event transfers on a rising clock edge where evt_valid and
// evt_ready are both high; while evt_valid is high and evt_ready is low the
// producer holds evt_ch/evt_rise stable and never withdraws evt_valid.
interface edge_event_arbiter_if #(
   parameter int CH_W = 2
);
   logic            evt_valid;
   logic            evt_ready;
   logic [CH_W-1:0] evt_ch;
   logic            evt_rise;

   modport master (
      output evt_valid,
      output evt_ch,
      output evt_rise,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_ch,
      input  evt_rise,
      output evt_ready
   );
endinterface

// File: rtl/edge_chan.sv
// One input channel: synchronizer chain, previous-sample flop and the
// enabled rising/falling edge strobes derived from them.
module edge_chan #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic rst,
   input  logic din,
   input  logic rise_en,
   input  logic fall_en,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_lvl;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_lvl;
      end
   end

   assign rise = sync_lvl & ~prev_q & rise_en;
   assign fall = ~sync_lvl & prev_q & fall_en;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge event controller: per-channel edge detection, one
// pending slot per channel, round-robin serialization onto one event stream.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter  int N_CH        = 4,
   parameter  int SYNC_STAGES = 2,
   localparam int CH_W        = $clog2(N_CH)
) (
   input  logic                clock,
   input  logic                rst,
   input  logic [N_CH-1:0]     din,
   input  logic [N_CH-1:0]     rise_en,
   input  logic [N_CH-1:0]     fall_en,
   input  logic                clr_ovf,
   output logic [N_CH-1:0]     overflow,
   output fsm_state_t          fsm_state,
   edge_event_arbiter_if.master evt
);

   localparam int              ARM_W   = arm_width(SYNC_STAGES);
   localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

   logic [N_CH-1:0]  ch_rise;
   logic [N_CH-1:0]  ch_fall;
   logic [N_CH-1:0]  edge_hit;
   logic [N_CH-1:0]  pend_q;
   logic [N_CH-1:0]  kind_q;
   logic [N_CH-1:0]  ovf_set;
   logic [N_CH-1:0]  edge_acc;
   logic [N_CH-1:0]  grant_oh;
   logic [ARM_W-1:0] arm_q;
   logic             armed;
   logic             any_pend;
   logic             take;
   logic [CH_W-1:0]  grant_idx;

   fsm_state_t       state_q;
   logic             valid_q;
   logic             rise_q;
   logic [CH_W-1:0]  ch_q;
   logic [CH_W-1:0]  ptr_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      edge_chan #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_chan (
         .clock   (clock),
         .rst     (rst),
         .din     (din[g]),
         .rise_en (rise_en[g]),
         .fall_en (fall_en[g]),
         .rise    (ch_rise[g]),
         .fall    (ch_fall[g])
      );
   end

   // Detection stays masked until the sync chains have filled with
   // post-reset samples, so levels present at release are not edges.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         arm_q <= '0;
      end else if (arm_q != ARM_MAX) begin
         arm_q <= arm_q + ARM_W'(1);
      end
   end

   assign armed    = (arm_q == ARM_MAX);
   assign edge_hit = (ch_rise | ch_fall) & {N_CH{armed}};

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      int j;
      j         = 0;
      grant_idx = '0;
      any_pend  = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N_CH) begin
            j = j - N_CH;
         end
         if (!any_pend && pend_q[j]) begin
            any_pend  = 1'b1;
            grant_idx = CH_W'(j);
         end
      end
   end

   assign take     = any_pend & (~valid_q | evt.evt_ready);
   assign grant_oh = take ? (N_CH'(1) << grant_idx) : '0;

   // A slot that is occupied and not being vacated this cycle drops the edge.
   assign ovf_set  = edge_hit & pend_q & ~grant_oh;
   assign edge_acc = edge_hit & ~ovf_set;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         pend_q   <= '0;
         kind_q   <= '0;
         overflow <= '0;
      end else begin
         pend_q   <= (pend_q & ~grant_oh) | edge_acc;
         kind_q   <= (kind_q & ~edge_acc) | (ch_rise & edge_acc);
         overflow <= (overflow & ~{N_CH{clr_ovf}}) | ovf_set;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         ch_q    <= '0;
         rise_q  <= EVT_FALL;
         ptr_q   <= CH_W'(N_CH - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (take) begin
                  state_q <= ST_OFFER;
                  valid_q <= 1'b1;
                  ch_q    <= grant_idx;
                  rise_q  <= kind_q[grant_idx];
                  ptr_q   <= grant_idx;
               end
            end
            ST_OFFER: begin
               if (evt.evt_ready) begin
                  if (take) begin
                     ch_q   <= grant_idx;
                     rise_q <= kind_q[grant_idx];
                     ptr_q  <= grant_idx;
                  end else begin
                     state_q <= ST_IDLE;
                     valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_ch    = ch_q;
   assign evt.evt_rise  = rise_q;
   assign fsm_state     = state_q;

   a_offer_hold: assert property (
      @(posedge clock) disable iff (rst)
      (valid_q && !evt.evt_ready) |=> (valid_q && $stable(ch_q) && $stable(rise_q))
   );

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

- Multi-channel edge-event controller that sits behind the single-channel synchronous edge detector.
- Synchronizes `N_CH` asynchronous inputs and detects enabled rising/falling edges per channel.
- Latches each edge as a pending event and serializes pending events to one valid/ready output port under round-robin arbitration.
- Downstream consumers (interrupt logic, counters, UART trigger) see one event stream carrying channel ID and edge polarity.

## Interface
- `N_CH`, 4: number of input channels (2..16)
- `SYNC_STAGES`, 2: synchronizer depth per channel (≥2)
- `CH_W`, $clog2(N_CH): channel ID width (derived localparam)
- `clock` in 1: single clock; all logic on rising edge
- `rst` in 1: reset, asynchronous and active-high; clears every flop
- `din` in N_CH: asynchronous level inputs
- `rise_en` in N_CH: per-channel rising-edge enable
- `fall_en` in N_CH: per-channel falling-edge enable
- `evt_valid` out 1: event offered
- `evt_ready` in 1: consumer accepts
- `evt_ch` out CH_W: channel of offered event
- `evt_rise` out 1: 1 = rising, 0 = falling
- `overflow` out N_CH: sticky, set when an edge is dropped
- `clr_ovf` in 1: one-cycle pulse clears all `overflow` bits

## Operation
- Reset values:
  - `evt_valid`=0, `evt_ch`=0, `evt_rise`=0, `overflow`=0.
  - Sync chains, previous-sample flops, pending bits and arm counter all 0.
  - RR pointer = N_CH-1, so channel 0 has first priority.
- Per channel: SYNC_STAGES flops, then a prev flop. rise = s & ~p & rise_en; fall = ~s & p & fall_en.
- Arm counter:
  - Counts from 0 after reset release and saturates at SYNC_STAGES+1.
  - Detection is gated off until saturation, so a level already present at reset release never produces an event.
- Pending: one bit plus one kind bit per channel. A detected edge sets pending and records its kind.
- Edge on a channel whose pending bit is set and not being granted this cycle:
  - New edge is dropped; stored kind is unchanged.
  - `overflow[ch]` is set.
- Edge in the same cycle its channel's pending is granted: the pending bit stays set with the new kind. No overflow.
- `clr_ovf` coincident with a new overflow: the set wins for that bit.
- Changing `rise_en`/`fall_en` never clears existing pending events.
- FSM states:
  - IDLE: `evt_valid`=0. If any pending, grant the first pending channel searching from ptr+1 with wrap-around. Load `evt_ch`/`evt_rise`, clear that pending bit, set ptr=granted channel, go to OFFER.
  - OFFER: `evt_valid`=1. `evt_ch`/`evt_rise` are held stable until `evt_valid & evt_ready`.
  - On handshake: if any pending, grant the next one immediately and stay in OFFER. Otherwise go to IDLE.
- Asynchronous `rst` mid-operation: `evt_valid` drops immediately; the offered event and all pending events are lost.

## Timing
- `din` change before edge 1 reaches the last sync stage at edge SYNC_STAGES.
  - Pending sets at edge SYNC_STAGES+1.
  - `evt_valid` rises after edge SYNC_STAGES+2 when the FSM is in IDLE (4 edges for the default).
- Throughput is one event per cycle while `evt_ready`=1 and events are pending; there is no bubble between events.
- `evt_valid` never deasserts without a handshake, except on reset.
- Outputs are registered; there is no combinational path from `evt_ready` to outputs.

## Structure
- Package `edge_arb_pkg`:
  - FSM state encoding (ST_IDLE, ST_OFFER).
  - Edge kind constants EVT_FALL=0, EVT_RISE=1.
- Sub-module `edge_chan`: one channel's synchronizer, prev flop and rise/fall outputs. Instantiated N_CH times via generate.
- Pending/overflow bookkeeping, arm counter, RR arbiter and FSM stay in the top module.

## Test plan
- Reset release with din=4'b0101 held, all enables on:
  - No event ever appears.
  - `overflow`=0.
- din[2] 0→1 with rise_en[2]=1, evt_ready=1:
  - `evt_valid` rises after edge 4, with evt_ch=2 and evt_rise=1.
  - `evt_valid` lasts one cycle.
- din[0], din[1], din[3] rise in the same cycle, evt_ready=1:
  - Events are issued back-to-back in order ch0, ch1, ch3 on three consecutive cycles.
  - Next simultaneous burst after that grants ch0 first again (ptr=3 wraps to 0).
- evt_ready=0 with ch1 offered:
  - Two further edges on ch1 set `overflow[1]`=1.
  - The offered event stays ch1 with its original kind.
  - After `clr_ovf`, overflow returns to 0.
- fall_en[3]=0, din[3] 1→0 → no event. Then fall_en[3]=1 with a further 1→0 → event ch3 with evt_rise=0.
- Assert `rst` while in OFFER with two events pending:
  - `evt_valid` goes to 0 asynchronously.
  - After release plus arm time, no stale event is issued.
